// File: rtl/clock_time_counter_pkg.sv
// Shared types and constants for the time-of-day counter.
package clock_time_counter_pkg;

    // Nanoseconds in one second; the nanosecond field always stays below this.
    localparam logic [31:0] NS_PER_SEC = 32'd1_000_000_000;

    // Signed nanosecond intermediate wide enough for -1e9 .. 2e9+period.
    typedef logic signed [32:0] ns33_t;

    // Registered view of the clock as seen by time consumers.
    typedef struct packed {
        logic [31:0] second;
        logic [31:0] nanosecond;
        logic        time_jump;
        logic        valid;
    } ClockTime_Type;

endpackage

// File: rtl/clock_time_normalize.sv
// Folds a signed nanosecond intermediate back into [0, 1e9) with one carry
// or borrow into the second field; the second wraps silently.
module clock_time_normalize
    import clock_time_counter_pkg::*;
(
    input  ns33_t       i_ns,
    input  logic [31:0] i_second,
    output logic [31:0] o_ns,
    output logic [31:0] o_second
);

    localparam ns33_t NS_PER_SEC_S = ns33_t'(NS_PER_SEC);

    // Single-step normalisation: the input range never needs more than one.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        o_ns     = 32'(i_ns);
        o_second = i_second;
        if (i_ns < 0) begin
            o_ns     = 32'(i_ns + NS_PER_SEC_S);
            o_second = i_second - 32'd1;
        end else if (i_ns >= NS_PER_SEC_S) begin
            o_ns     = 32'(i_ns - NS_PER_SEC_S);
            o_second = i_second + 32'd1;
        end
    end

endmodule

// File: rtl/clock_time_counter.sv
// Free-running second/nanosecond counter with absolute set, signed offset
// step and linear drift correction. All outputs are registered.
module clock_time_counter
    import clock_time_counter_pkg::*;
#(
    parameter int ClockPeriod_Gen = 20,
    parameter int MaxOffset_Gen   = 999_999_999
) (
    input  logic        SysClk_ClkIn,
    input  logic        SysRstN_RstIn,
    input  logic [31:0] TimeSet_Second_DatIn,
    input  logic [31:0] TimeSet_Nanosecond_DatIn,
    input  logic        TimeSet_ValIn,
    output logic        TimeSet_AckOut,
    input  logic [31:0] Offset_DatIn,
    input  logic        Offset_ValIn,
    output logic        Offset_AckOut,
    input  logic [31:0] DriftInterval_DatIn,
    input  logic        DriftSign_DatIn,
    output logic        Adj_ErrOut,
    output logic [31:0] ClockTime_Second_DatOut,
    output logic [31:0] ClockTime_Nanosecond_DatOut,
    output logic        ClockTime_TimeJump_DatOut,
    output logic        ClockTime_ValOut
);

    localparam ns33_t PERIOD_NS  = ns33_t'(ClockPeriod_Gen);
    localparam ns33_t MAX_OFFSET = ns33_t'(MaxOffset_Gen);

    ClockTime_Type r_clock_time;
    logic [31:0]   r_drift_cnt;
    logic          r_set_ack;
    logic          r_offset_ack;
    logic          r_adj_err;

    logic          w_drift_fire;
    logic          w_drift_clear;
    ns33_t         w_drift_adj;
    ns33_t         w_offset;
    logic          w_offset_in_range;
    logic          w_set_ok;
    logic          w_apply_offset;
    ns33_t         w_ns_sum;
    logic [31:0]   w_next_ns;
    logic [31:0]   w_next_second;

    // Drift pacing and request qualification.
    always_comb begin
        w_drift_fire  = (DriftInterval_DatIn != 32'd0) &&
                        (r_drift_cnt == DriftInterval_DatIn - 32'd1);
        // A shrunk interval at or below the current count restarts the count.
        w_drift_clear = (DriftInterval_DatIn == 32'd0) ||
                        (r_drift_cnt >= DriftInterval_DatIn);
        w_drift_adj   = '0;
        if (w_drift_fire) begin
            w_drift_adj = DriftSign_DatIn ? -ns33_t'(1) : ns33_t'(1);
        end

        w_offset          = ns33_t'(signed'(Offset_DatIn));
        w_offset_in_range = (w_offset <= MAX_OFFSET) && (w_offset >= -MAX_OFFSET);
        w_set_ok          = TimeSet_Nanosecond_DatIn < NS_PER_SEC;
        // A simultaneous TimeSet always wins, even if the set itself is rejected.
        w_apply_offset    = Offset_ValIn && !TimeSet_ValIn && w_offset_in_range;

        w_ns_sum = ns33_t'({1'b0, r_clock_time.nanosecond}) + PERIOD_NS + w_drift_adj;
        if (w_apply_offset) begin
            w_ns_sum = w_ns_sum + w_offset;
        end
    end

    clock_time_normalize u_normalize (
        .i_ns     (w_ns_sum),
        .i_second (r_clock_time.second),
        .o_ns     (w_next_ns),
        .o_second (w_next_second)
    );

    // Drift counter: counts 0 .. interval-1 and restarts on each correction.
    always_ff @(posedge SysClk_ClkIn or negedge SysRstN_RstIn) begin
        if (!SysRstN_RstIn) begin
            r_drift_cnt <= '0;
        end else if (w_drift_fire || w_drift_clear) begin
            r_drift_cnt <= '0;
        end else begin
            r_drift_cnt <= r_drift_cnt + 32'd1;
        end
    end

    // Time registers with priority TimeSet > Offset > normal tick.
    always_ff @(posedge SysClk_ClkIn or negedge SysRstN_RstIn) begin
        if (!SysRstN_RstIn) begin
            r_clock_time <= '0;
            r_set_ack    <= 1'b0;
            r_offset_ack <= 1'b0;
            r_adj_err    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            r_adj_err <= (TimeSet_ValIn && !w_set_ok) ||
                         (Offset_ValIn && (TimeSet_ValIn || !w_offset_in_range));
            if (TimeSet_ValIn && w_set_ok) begin
                r_clock_time.second     <= TimeSet_Second_DatIn;
                r_clock_time.nanosecond <= TimeSet_Nanosecond_DatIn;
                r_clock_time.time_jump  <= 1'b1;
                r_clock_time.valid      <= 1'b1;
                r_set_ack               <= 1'b1;
                r_offset_ack            <= 1'b0;
            end else begin
                r_clock_time.second     <= w_next_second;
                r_clock_time.nanosecond <= w_next_ns;
                r_clock_time.time_jump  <= w_apply_offset;
                r_set_ack               <= 1'b0;
                r_offset_ack            <= w_apply_offset;
            end
        end
    end

    assign TimeSet_AckOut              = r_set_ack;
    assign Offset_AckOut               = r_offset_ack;
    assign Adj_ErrOut                  = r_adj_err;
    assign ClockTime_Second_DatOut     = r_clock_time.second;
    assign ClockTime_Nanosecond_DatOut = r_clock_time.nanosecond;
    assign ClockTime_TimeJump_DatOut   = r_clock_time.time_jump;
    assign ClockTime_ValOut            = r_clock_time.valid;

endmodule

// File: tb/tb_clock_time_counter.sv
// Directed bench for clock_time_counter with ClockPeriod_Gen = 20.
module tb_clock_time_counter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] set_sec = '0;
    logic [31:0] set_ns = '0;
    logic        set_val = 1'b0;
    logic        set_ack;
    logic [31:0] off_dat = '0;
    logic        off_val = 1'b0;
    logic        off_ack;
    logic [31:0] drift_int = '0;
    logic        drift_sign = 1'b0;
    logic        adj_err;
    logic [31:0] out_sec;
    logic [31:0] out_ns;
    logic        out_jump;
    logic        out_val;

    int n_checks = 0;
    int n_errors = 0;

    clock_time_counter #(
        .ClockPeriod_Gen (20),
        .MaxOffset_Gen   (999_999_999)
    ) dut (
        .SysClk_ClkIn                (clk),
        .SysRstN_RstIn               (rst_n),
        .TimeSet_Second_DatIn        (set_sec),
        .TimeSet_Nanosecond_DatIn    (set_ns),
        .TimeSet_ValIn               (set_val),
        .TimeSet_AckOut              (set_ack),
        .Offset_DatIn                (off_dat),
        .Offset_ValIn                (off_val),
        .Offset_AckOut               (off_ack),
        .DriftInterval_DatIn         (drift_int),
        .DriftSign_DatIn             (drift_sign),
        .Adj_ErrOut                  (adj_err),
        .ClockTime_Second_DatOut     (out_sec),
        .ClockTime_Nanosecond_DatOut (out_ns),
        .ClockTime_TimeJump_DatOut   (out_jump),
        .ClockTime_ValOut            (out_val)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", tag, act, act, exp, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_time(input string tag, input logic [31:0] s, input logic [31:0] ns);
        check({tag, ".sec"}, out_sec, s);
        check({tag, ".ns"}, out_ns, ns);
    endtask

    // Load a time and leave it displayed; strobes cleared afterwards.
    task automatic do_set(input logic [31:0] s, input logic [31:0] ns);
        set_sec = s;
        set_ns  = ns;
        set_val = 1'b1;
        tick();
        set_val = 1'b0;
    endtask

    task automatic do_offset(input logic [31:0] off);
        off_dat = off;
        off_val = 1'b1;
        tick();
        off_val = 1'b0;
    endtask

    logic [31:0] prev_ns;
    logic [31:0] exp_delta;

    initial begin
        // Reset state
        #3;
        check_time("rst", 32'd0, 32'd0);
        check("rst.val", {31'd0, out_val}, 32'd0);
        check("rst.jump", {31'd0, out_jump}, 32'd0);
        check("rst.err", {31'd0, adj_err}, 32'd0);
        #9 rst_n = 1'b1;

        // Free run after reset without a set
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("run.ns", out_ns, 32'(20 * i));
            check("run.val", {31'd0, out_val}, 32'd0);
            check("run.jump", {31'd0, out_jump}, 32'd0);
        end

        // Set near the top of a second and wrap
        do_set(32'd5, 32'd999_999_960);
        check_time("wrap0", 32'd5, 32'd999_999_960);
        check("wrap0.jump", {31'd0, out_jump}, 32'd1);
        check("wrap0.ack", {31'd0, set_ack}, 32'd1);
        check("wrap0.val", {31'd0, out_val}, 32'd1);
        tick();
        check_time("wrap1", 32'd5, 32'd999_999_980);
        check("wrap1.jump", {31'd0, out_jump}, 32'd0);
        check("wrap1.ack", {31'd0, set_ack}, 32'd0);
        tick();
        check_time("wrap2", 32'd6, 32'd0);
        check("wrap2.jump", {31'd0, out_jump}, 32'd0);

        // Out-of-range nanosecond set is rejected and time ticks on
        do_set(32'd99, 32'd1_000_000_000);
        check_time("badset", 32'd6, 32'd20);
        check("badset.err", {31'd0, adj_err}, 32'd1);
        check("badset.ack", {31'd0, set_ack}, 32'd0);
        check("badset.jump", {31'd0, out_jump}, 32'd0);

        // Positive offset
        do_set(32'd10, 32'd500);
        do_offset(32'd100);
        check_time("offp", 32'd10, 32'd620);
        check("offp.jump", {31'd0, out_jump}, 32'd1);
        check("offp.ack", {31'd0, off_ack}, 32'd1);
        check("offp.err", {31'd0, adj_err}, 32'd0);
        tick();
        check("offp.jump_after", {31'd0, out_jump}, 32'd0);

        // Negative offset with borrow
        do_set(32'd10, 32'd500);
        do_offset(-32'sd1000);
        check_time("offn", 32'd9, 32'd999_999_520);
        check("offn.jump", {31'd0, out_jump}, 32'd1);
        check("offn.ack", {31'd0, off_ack}, 32'd1);

        // Largest negative offset accepted
        do_set(32'd10, 32'd500);
        do_offset(-32'sd999_999_999);
        check_time("offmin", 32'd9, 32'd521);
        check("offmin.ack", {31'd0, off_ack}, 32'd1);

        // One beyond the limit is rejected
        do_set(32'd10, 32'd500);
        do_offset(32'd1_000_000_000);
        check_time("offbig", 32'd10, 32'd520);
        check("offbig.err", {31'd0, adj_err}, 32'd1);
        check("offbig.ack", {31'd0, off_ack}, 32'd0);

        // Huge offset rejected
        do_set(32'd10, 32'd500);
        do_offset(32'h7FFF_FFFF);
        check_time("offmax", 32'd10, 32'd520);
        check("offmax.err", {31'd0, adj_err}, 32'd1);
        check("offmax.jump", {31'd0, out_jump}, 32'd0);
        check("offmax.ack", {31'd0, off_ack}, 32'd0);

        // Set and offset in the same cycle
        set_sec = 32'd1;
        set_ns  = 32'd0;
        set_val = 1'b1;
        off_dat = 32'd50;
        off_val = 1'b1;
        tick();
        set_val = 1'b0;
        off_val = 1'b0;
        check_time("coll", 32'd1, 32'd0);
        check("coll.setack", {31'd0, set_ack}, 32'd1);
        check("coll.err", {31'd0, adj_err}, 32'd1);
        check("coll.offack", {31'd0, off_ack}, 32'd0);

        // Drift +1 every 4th cycle
        do_set(32'd0, 32'd1000);
        drift_int  = 32'd4;
        drift_sign = 1'b0;
        for (int i = 0; i < 8; i++) begin
            prev_ns = out_ns;
            tick();
            exp_delta = (i % 4 == 3) ? 32'd21 : 32'd20;
            check("drift_up.delta", out_ns - prev_ns, exp_delta);
            check("drift_up.jump", {31'd0, out_jump}, 32'd0);
        end
        drift_int = 32'd0;
        tick();

        // Drift -1 every 4th cycle
        drift_int  = 32'd4;
        drift_sign = 1'b1;
        for (int i = 0; i < 8; i++) begin
            prev_ns = out_ns;
            tick();
            exp_delta = (i % 4 == 3) ? 32'd19 : 32'd20;
            check("drift_dn.delta", out_ns - prev_ns, exp_delta);
        end
        drift_int  = 32'd0;
        drift_sign = 1'b0;

        // Asynchronous reset in the middle of a run
        do_set(32'd7, 32'd123_460);
        check_time("pre_rst", 32'd7, 32'd123_460);
        #2 rst_n = 1'b0;
        #1;
        check_time("async_rst", 32'd0, 32'd0);
        check("async_rst.val", {31'd0, out_val}, 32'd0);
        check("async_rst.jump", {31'd0, out_jump}, 32'd0);
        check("async_rst.ack", {31'd0, set_ack}, 32'd0);
        #3 rst_n = 1'b1;
        tick();
        check_time("post_rst", 32'd0, 32'd20);
        check("post_rst.val", {31'd0, out_val}, 32'd0);

        // Offset accepted while time is not yet valid
        do_offset(32'd100);
        check_time("off_inval", 32'd0, 32'd140);
        check("off_inval.ack", {31'd0, off_ack}, 32'd1);
        check("off_inval.jump", {31'd0, out_jump}, 32'd1);
        check("off_inval.val", {31'd0, out_val}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
